fcmp_ctrl: RTL and testbench

Floating-point compare controller for the RV32F execution path. It accepts FEQ.S, FLT.S, FLE.S and optionally FMIN.S/FMAX.S requests over a valid/ready handshake, screens NaN and signed-zero cases, and sequences the shared 32-bit comparator by driving sign-stripped magnitude operands and sampling its L/E/G result. It returns the integer or FP result, the NV exception flag and the request tag to writeback.

---
 rtl/fcmp_ctrl.sv | 155 +++++++++++++++
 tb/tb_fcmp_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fcmp_ctrl.sv
// RV32F compare controller: FEQ/FLT/FLE (plus FMIN/FMAX when FCMP_MINMAX_EN is defined),
// with NaN/illegal-op fast path and a single-cycle shared-comparator sample.
module fcmp_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_g,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_nv,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
`ifdef FCMP_MINMAX_EN
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;
`endif

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  logic [1:0]  state;
  logic        rdy_en;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;

  // Held low through reset and set on the first clock afterwards.
  assign req_ready = rdy_en && (state == IDLE);
  assign rsp_valid = (state == RESP);

  logic a_nan, b_nan, a_snan, b_snan, any_nan, any_snan, op_legal, fast;
  logic [31:0] fast_data;
  logic        fast_nv;

  assign a_nan    = (&req_a[30:23]) && (|req_a[22:0]);
  assign b_nan    = (&req_b[30:23]) && (|req_b[22:0]);
  assign a_snan   = a_nan && !req_a[22];
  assign b_snan   = b_nan && !req_b[22];
  assign any_nan  = a_nan || b_nan;
  assign any_snan = a_snan || b_snan;
`ifdef FCMP_MINMAX_EN
  assign op_legal = (req_op <= 3'd4);
`else
  assign op_legal = (req_op <= 3'd2);
`endif
  assign fast = any_nan || !op_legal;

  always_comb begin
    fast_data = '0;
    fast_nv   = 1'b0;
    if (op_legal) begin
      case (req_op)
        OP_FEQ:         fast_nv = any_snan;
        OP_FLT, OP_FLE: fast_nv = any_nan;
`ifdef FCMP_MINMAX_EN
        OP_FMIN, OP_FMAX: begin
          fast_nv = any_snan;
          if (a_nan && b_nan) fast_data = CANON_NAN;
          else if (a_nan)     fast_data = req_b;
          else                fast_data = req_a;
        end
`endif
        default: ;
      endcase
    end
  end

  logic sa, sb, z, eq, lt;
  logic [31:0] norm_data;

  assign sa = a_q[31];
  assign sb = b_q[31];
  assign z  = (a_q[30:0] == 31'd0) && (b_q[30:0] == 31'd0);
  assign eq = z || ((sa == sb) && cmp_e);
  assign lt = !z && ((sa && !sb) || (!sa && !sb && cmp_l) || (sa && sb && cmp_g));

  always_comb begin
    norm_data = '0;
    case (op_q)
      OP_FEQ: norm_data = {31'd0, eq};
      OP_FLT: norm_data = {31'd0, lt};
      OP_FLE: norm_data = {31'd0, lt || eq};
`ifdef FCMP_MINMAX_EN
      // Opposite-signed zeros compare equal, so pick by sign rather than lt.
      OP_FMIN: norm_data = (z && (sa != sb)) ? (sa ? a_q : b_q) : (lt ? a_q : b_q);
      OP_FMAX: norm_data = (z && (sa != sb)) ? (sa ? b_q : a_q) : (lt ? b_q : a_q);
`endif
      default: norm_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      rsp_data <= '0;
      rsp_nv   <= 1'b0;
      rsp_tag  <= '0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            rsp_tag <= req_tag;
            cmp_a   <= {1'b0, req_a[30:0]};
            cmp_b   <= {1'b0, req_b[30:0]};
            if (fast) begin
              rsp_data <= fast_data;
              rsp_nv   <= fast_nv;
              state    <= RESP;
            end else begin
              state <= CMP;
            end
          end
        end
        CMP: begin
          rsp_data <= norm_data;
          rsp_nv   <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcmp_ctrl.sv
// Directed-vector bench for fcmp_ctrl with a behavioural magnitude comparator.
module tb_fcmp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_l, cmp_e, cmp_g;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_nv;
  logic [3:0]  rsp_tag;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign cmp_l = (cmp_a <  cmp_b);
  assign cmp_e = (cmp_a == cmp_b);
  assign cmp_g = (cmp_a >  cmp_b);

  fcmp_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nv(rsp_nv), .rsp_tag(rsp_tag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from a point #1 after an edge; checks latency and result.
  task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] tag,
                     input logic [31:0] ed, input logic en, input logic fast);
    chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    tick();
    req_valid = 1'b0;
    chk({nm, " busy"}, {31'd0, req_ready}, 32'd0);
    if (!fast) begin
      chk({nm, " cmp_wait"}, {31'd0, rsp_valid}, 32'd0);
      chk({nm, " cmp_a"}, cmp_a, {1'b0, a[30:0]});
      chk({nm, " cmp_b"}, cmp_b, {1'b0, b[30:0]});
      tick();
    end
    chk({nm, " valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, " data"}, rsp_data, ed);
    chk({nm, " nv"}, {31'd0, rsp_nv}, {31'd0, en});
    chk({nm, " tag"}, {28'd0, rsp_tag}, {28'd0, tag});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({nm, " done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_tag = '0; rsp_ready = 1'b0;
    #2;
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst cmp_a", cmp_a, 32'd0);
    chk("rst rsp_tag", {28'd0, rsp_tag}, 32'd0);
    tick();
    @(negedge clk); rst = 1'b0;
    tick();

    run("flt_1_2",   3'b001, 32'h3F80_0000, 32'h4000_0000, 4'h1, 32'd1, 1'b0, 1'b0);
    run("fle_m1_m2", 3'b010, 32'hBF80_0000, 32'hC000_0000, 4'h2, 32'd0, 1'b0, 1'b0);
    run("flt_m2_m1", 3'b001, 32'hC000_0000, 32'hBF80_0000, 4'h3, 32'd1, 1'b0, 1'b0);
    run("feq_pz_nz", 3'b000, 32'h0000_0000, 32'h8000_0000, 4'h4, 32'd1, 1'b0, 1'b0);
    run("flt_pz_nz", 3'b001, 32'h0000_0000, 32'h8000_0000, 4'h5, 32'd0, 1'b0, 1'b0);
`ifdef FCMP_MINMAX_EN
    run("fmin_zero", 3'b011, 32'h0000_0000, 32'h8000_0000, 4'h6, 32'h8000_0000, 1'b0, 1'b0);
    run("fmax_zero", 3'b100, 32'h0000_0000, 32'h8000_0000, 4'h7, 32'h0000_0000, 1'b0, 1'b0);
    run("fmax_1_2",  3'b100, 32'h3F80_0000, 32'h4000_0000, 4'h8, 32'h4000_0000, 1'b0, 1'b0);
    run("fmin_m2_1", 3'b011, 32'hC000_0000, 32'h3F80_0000, 4'h9, 32'hC000_0000, 1'b0, 1'b0);
    run("fmin_snan", 3'b011, 32'h7F80_0001, 32'h3F80_0000, 4'hA, 32'h3F80_0000, 1'b1, 1'b1);
    run("fmax_qq",   3'b100, 32'h7FC0_0000, 32'h7FC0_0001, 4'hB, 32'h7FC0_0000, 1'b0, 1'b1);
`else
    run("fmin_zero", 3'b011, 32'h0000_0000, 32'h8000_0000, 4'h6, 32'd0, 1'b0, 1'b1);
    run("fmax_zero", 3'b100, 32'h0000_0000, 32'h8000_0000, 4'h7, 32'd0, 1'b0, 1'b1);
    run("fmin_snan", 3'b011, 32'h7F80_0001, 32'h3F80_0000, 4'hA, 32'd0, 1'b0, 1'b1);
`endif
    run("feq_qnan",  3'b000, 32'h7FC0_0000, 32'h3F80_0000, 4'hC, 32'd0, 1'b0, 1'b1);
    run("flt_qnan",  3'b001, 32'h7FC0_0000, 32'h3F80_0000, 4'hD, 32'd0, 1'b1, 1'b1);
    run("feq_snan",  3'b000, 32'h7F80_0001, 32'h3F80_0000, 4'hE, 32'd0, 1'b1, 1'b1);
    run("op_101",    3'b101, 32'h3F80_0000, 32'h3F80_0000, 4'hF, 32'd0, 1'b0, 1'b1);

    // Backpressure: hold rsp_ready low while a competing request is offered.
    req_valid = 1'b1; req_op = 3'b001; req_a = 32'h3F80_0000; req_b = 32'h4000_0000;
    req_tag = 4'h5;
    tick();
    req_tag = 4'h9; req_op = 3'b000;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp data", rsp_data, 32'd1);
      chk("bp tag", {28'd0, rsp_tag}, 32'd5);
      chk("bp ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp release", {31'd0, rsp_valid}, 32'd0);

    // Reset while in CMP discards the request.
    req_valid = 1'b1; req_op = 3'b001; req_a = 32'h3F80_0000; req_b = 32'h4000_0000;
    req_tag = 4'h3;
    tick();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstc rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstc req_ready", {31'd0, req_ready}, 32'd0);
    chk("rstc cmp_a", cmp_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("rstc ready_after", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rstc no_stale", {31'd0, rsp_valid}, 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
